// File: rtl/instruction_fetch.sv
// Instruction fetch stage: FETCH -> WAIT -> VALID handshake with memory, PC sequencing and redirects.
// Optional alignment trap with HALT state is compiled in with the IFETCH_MISALIGN_TRAP_EN macro.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          OPCODE_LENGTH = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ready,
    input  logic [31:0]              imem_rdata,
    input  logic                     stall,
    input  logic                     branch_taken,
    input  logic [31:0]              branch_target,
    input  logic                     jump,
    input  logic [25:0]              jump_index,
    output logic [31:0]              instr,
    output logic [OPCODE_LENGTH-1:0] opcode,
    output logic                     instr_valid,
    output logic [31:0]              pc,
    output logic [31:0]              pc_plus4,
    output logic [31:0]              fetch_count
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    output logic                     misalign
`endif
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
`ifdef IFETCH_MISALIGN_TRAP_EN
        ST_VALID = 2'd2,
        ST_HALT  = 2'd3
`else
        ST_VALID = 2'd2
`endif
    } state_e;

    state_e      state_r;
    state_e      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] instr_r;
    logic [31:0] instr_next_s;
    logic [31:0] count_r;
    logic [31:0] count_next_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] raw_target_s;
    logic [31:0] target_s;

    // Redirect selection: jump beats branch beats sequential.
    always_comb begin
        pc_plus4_s   = pc_r + 32'd4;
        raw_target_s = pc_plus4_s;
        if (jump) begin
            raw_target_s = {pc_plus4_s[31:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            raw_target_s = branch_target;
        end else begin
            raw_target_s = pc_plus4_s;
        end
`ifdef IFETCH_MISALIGN_TRAP_EN
        target_s = raw_target_s;
`else
        target_s = {raw_target_s[31:2], 2'b00};
`endif
    end

    // Next-state logic; redirects only matter when VALID is consumed.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        instr_next_s = instr_r;
        count_next_s = count_r;
        case (state_r)
            ST_FETCH: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_ready) begin
                    instr_next_s = imem_rdata;
                    state_next_s = ST_VALID;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_VALID: begin
                if (!stall) begin
                    count_next_s = count_r + 32'd1;
                    pc_next_s    = target_s;
`ifdef IFETCH_MISALIGN_TRAP_EN
                    if (target_s[1:0] != 2'b00) begin
                        state_next_s = ST_HALT;
                    end else begin
                        state_next_s = ST_FETCH;
                    end
`else
                    state_next_s = ST_FETCH;
`endif
                end else begin
                    state_next_s = ST_VALID;
                end
            end
`ifdef IFETCH_MISALIGN_TRAP_EN
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
`endif
            default: begin
                state_next_s = ST_FETCH;
            end
        endcase
    end

    // State, PC, instruction and retire counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FETCH;
            pc_r    <= RESET_PC;
            instr_r <= 32'h0000_0000;
            count_r <= 32'd0;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            instr_r <= instr_next_s;
            count_r <= count_next_s;
        end
    end

    // Handshake outputs decoded from the state register, forced low while reset is held.
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        if (rst) begin
            imem_req    = 1'b0;
            instr_valid = 1'b0;
        end else begin
            imem_req    = (state_r == ST_FETCH) || (state_r == ST_WAIT);
            instr_valid = (state_r == ST_VALID);
        end
    end

    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign opcode      = instr_r[31 -: OPCODE_LENGTH];
    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_s;
    assign fetch_count = count_r;
`ifdef IFETCH_MISALIGN_TRAP_EN
    assign misalign    = (state_r == ST_HALT);
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] fetch_count;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase 0 = issuing, 1 = awaiting data, 2 = holding instruction, 3 = trapped
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_count;

    always #5 clk = ~clk;

    instruction_fetch #(
        .RESET_PC      (RESET_PC),
        .OPCODE_LENGTH (6)
    ) dut (
`ifdef IFETCH_MISALIGN_TRAP_EN
        .misalign      (misalign),
`endif
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .instr         (instr),
        .opcode        (opcode),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .fetch_count   (fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [31:0] seq;
        logic [31:0] nxt;
        if (rst) begin
            m_phase = 0;
            m_pc    = RESET_PC;
            m_instr = 32'd0;
            m_count = 32'd0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (imem_ready) begin
                m_instr = imem_rdata;
                m_phase = 2;
            end
        end else if (m_phase == 2 && !stall) begin
            m_count = m_count + 32'd1;
            seq     = m_pc + 32'd4;
            if (jump) nxt = (seq & 32'hF000_0000) | ({6'd0, jump_index} << 2);
            else if (branch_taken) nxt = branch_target;
            else nxt = seq;
`ifdef IFETCH_MISALIGN_TRAP_EN
            m_pc    = nxt;
            m_phase = (nxt % 32'd4 != 32'd0) ? 3 : 0;
`else
            m_pc    = nxt - (nxt % 32'd4);
            m_phase = 0;
`endif
        end
    endtask

    task automatic compare_model();
        logic exp_req;
        logic exp_valid;
        n_vec++;
        exp_req   = !rst && (m_phase == 0 || m_phase == 1);
        exp_valid = !rst && (m_phase == 2);
        chk("model_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("model_addr", imem_addr, m_pc);
        chk("model_valid", 32'(instr_valid), 32'(exp_valid));
        chk("model_pc", pc, m_pc);
        chk("model_instr", instr, m_instr);
        chk("model_opcode", 32'(opcode), 32'(m_instr[31:26]));
        chk("model_pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("model_count", fetch_count, m_count);
`ifdef IFETCH_MISALIGN_TRAP_EN
        chk("model_misalign", 32'(misalign), 32'(m_phase == 3));
`endif
    endtask

    task automatic to_neg();
        @(negedge clk);
        compare_model();
    endtask

    task automatic to_pos();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cyc();
        to_neg();
        to_pos();
    endtask

    task automatic clear_redirect();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        jump          = 1'b0;
        branch_target = 32'd0;
        jump_index    = 26'd0;
    endtask

    // One FETCH cycle, lat WAIT cycles without ready, then the ready cycle; ends in VALID.
    task automatic fetch_instr(input int lat, input logic [31:0] data, input logic [31:0] exp_addr);
        imem_ready = 1'b0;
        to_neg();
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, exp_addr);
        chk("fetch_novalid", 32'(instr_valid), 32'd0);
        to_pos();
        for (int i = 0; i < lat; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            to_neg();
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", imem_addr, exp_addr);
            chk("wait_novalid", 32'(instr_valid), 32'd0);
            to_pos();
        end
        imem_ready = 1'b1;
        imem_rdata = data;
        to_neg();
        chk("ready_req", 32'(imem_req), 32'd1);
        chk("ready_addr", imem_addr, exp_addr);
        to_pos();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        chk("latched_instr", instr, data);
    endtask

    initial begin
        m_phase    = 0;
        m_pc       = RESET_PC;
        m_instr    = 32'd0;
        m_count    = 32'd0;
        rst        = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
        clear_redirect();

        // Reset values
        to_pos();
        to_neg();
        chk("rst_pc", pc, RESET_PC);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        to_pos();
        rst = 1'b0;

        // Back-to-back sequential fetches with one-cycle memory latency
        for (int i = 0; i < 3; i++) begin
            fetch_instr(0, 32'h2408_0005, 32'(i * 4));
            to_neg();
            chk("seq_valid", 32'(instr_valid), 32'd1);
            chk("seq_opcode", 32'(opcode), 32'h0000_0009);
            to_pos();
            chk("seq_count", fetch_count, 32'(i + 1));
        end

        // Slow memory, then a stall with a branch that must be ignored
        fetch_instr(3, 32'h8C01_0004, 32'h0000_000C);
        for (int k = 0; k < 4; k++) begin
            stall         = 1'b1;
            branch_taken  = (k == 1 || k == 2);
            branch_target = 32'h0000_3000;
            to_neg();
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_pc", pc, 32'h0000_000C);
            chk("stall_instr", instr, 32'h8C01_0004);
            to_pos();
        end
        clear_redirect();
        cyc();
        fetch_instr(0, 32'h0000_0000, 32'h0000_0010);

        // Branch to 0x1000, then jump and branch together: jump wins
        branch_taken  = 1'b1;
        branch_target = 32'h0000_1000;
        cyc();
        clear_redirect();
        fetch_instr(0, 32'h0800_0040, 32'h0000_1000);
        jump          = 1'b1;
        jump_index    = 26'h000_0040;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_2000;
        cyc();
        clear_redirect();
        fetch_instr(0, 32'h1111_2222, 32'h0000_0100);

        // pc_plus4 wraps at the top of the address space
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        cyc();
        clear_redirect();
        fetch_instr(0, 32'h3333_4444, 32'hFFFF_FFFC);
        to_neg();
        chk("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
        to_pos();
        fetch_instr(1, 32'h5555_6666, 32'h0000_0000);

        // Misaligned redirect
        branch_taken  = 1'b1;
        branch_target = 32'h0000_2002;
        cyc();
        clear_redirect();
`ifdef IFETCH_MISALIGN_TRAP_EN
        for (int k = 0; k < 4; k++) begin
            imem_ready = 1'b1;
            to_neg();
            chk("halt_misalign", 32'(misalign), 32'd1);
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_valid", 32'(instr_valid), 32'd0);
            chk("halt_pc", pc, 32'h0000_2002);
            to_pos();
        end
        imem_ready = 1'b0;
`else
        fetch_instr(0, 32'h7777_8888, 32'h0000_2000);
        cyc();
        to_neg();
        to_pos();
`endif

        // Reset during WAIT (or HALT), stale ready afterwards must be ignored
        rst = 1'b1;
        to_neg();
        chk("rst_wait_req", 32'(imem_req), 32'd0);
        to_pos();
        rst        = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        to_neg();
        chk("restart_req", 32'(imem_req), 32'd1);
        chk("restart_addr", imem_addr, RESET_PC);
        chk("restart_count", fetch_count, 32'd0);
        to_pos();
        imem_rdata = 32'h1234_5678;
        to_neg();
        chk("stale_ignored", 32'(instr_valid), 32'd0);
        to_pos();
        imem_ready = 1'b0;
        chk("restart_instr", instr, 32'h1234_5678);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 63) == 0);
            imem_ready    = ($urandom_range(0, 1) == 1);
            imem_rdata    = $urandom;
            stall         = ($urandom_range(0, 2) == 0);
            branch_taken  = ($urandom_range(0, 3) == 0);
            branch_target = $urandom;
            if ($urandom_range(0, 7) != 0) branch_target[1:0] = 2'b00;
            jump          = ($urandom_range(0, 7) == 0);
            jump_index    = 26'($urandom);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: OPCODE_LENGTH, 6, width of the opcode field presented to the control decoder.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  word-aligned byte address of the fetch.
REQ-007 imem_ready  input  1  memory response strobe; imem_rdata is valid this cycle.
REQ-008 imem_rdata  input  32  instruction word returned by memory.
REQ-009 stall  input  1  downstream not ready; hold the current instruction.
REQ-010 branch_taken  input  1  redirect to branch_target.
REQ-011 branch_target  input  32  branch destination byte address.
REQ-012 jump  input  1  redirect to the J-type target.
REQ-013 jump_index  input  26  J-type instr_index field.
REQ-014 instr  output  32  latched instruction word.
REQ-015 opcode  output  OPCODE_LENGTH  instr[31:26], feeds the control decoder.
REQ-016 instr_valid  output  1  instr, opcode and pc_plus4 are valid.
REQ-017 pc  output  32  address of the instruction in instr.
REQ-018 pc_plus4  output  32  pc + 4, modulo 2^32.
REQ-019 fetch_count  output  32  number of instructions retired out of this stage.

Function
REQ-020 The FSM SHALL have the states FETCH, WAIT and VALID, plus HALT when the macro in REQ-035 is defined.
- FETCH: imem_req=1, imem_addr=pc; go to WAIT next cycle.
REQ-021 In WAIT, imem_req SHALL stay 1 with a stable imem_addr until imem_ready=1.
- On that cycle, instr is latched from imem_rdata and the FSM goes to VALID.
REQ-022 An imem_ready seen in WAIT on the same cycle the FSM is entered SHALL be accepted (minimum latency: FETCH->WAIT->VALID, instr_valid high 2 cycles after FETCH).
REQ-023 In FETCH and WAIT, imem_ready SHALL be ignored outside WAIT, and instr_valid=0.
REQ-024 In VALID, instr_valid SHALL be 1.
- While stall=1, instr, pc and the FSM SHALL hold, and redirect inputs SHALL be ignored.
REQ-025 In VALID with stall=0, the stage SHALL consume the instruction:
- fetch_count increments by 1 (wraps at 2^32);
- pc loads next_pc;
- FSM goes to FETCH.
REQ-026 next_pc priority SHALL be:
- jump: {pc_plus4[31:28], jump_index, 2'b00};
- else branch_taken: branch_target;
- else pc_plus4.
REQ-027 branch_taken and jump SHALL be sampled only in VALID with stall=0; they SHALL be ignored in all other states.
REQ-028 pc_plus4 SHALL wrap: pc=32'hFFFF_FFFC gives pc_plus4=32'h0000_0000, with no flag.
REQ-029 opcode SHALL equal instr[31:26] combinationally at all times.

Reset
REQ-030 When rst=1 at a clock edge, the stage SHALL apply its reset values (this takes priority over all other inputs):
- pc=RESET_PC, instr=0, fetch_count=0;
- FSM=FETCH, instr_valid=0, imem_req=0 in the reset cycle.
REQ-031 A reset asserted during WAIT SHALL abandon the outstanding request.
- An imem_ready arriving after reset and before the new FETCH->WAIT SHALL be ignored.
REQ-032 The first request after reset deassertion SHALL be issued in the following cycle at RESET_PC.

Configuration
REQ-033 The macro IFETCH_MISALIGN_TRAP_EN SHALL compile the alignment-trap feature in or out.
REQ-034 With IFETCH_MISALIGN_TRAP_EN defined, an extra output misalign (1 bit) SHALL exist:
- if a selected redirect target has [1:0]!=0, the FSM enters HALT;
- in HALT: misalign=1, imem_req=0, instr_valid=0, pc holds the faulting target;
- HALT exits only on rst.
REQ-035 Without IFETCH_MISALIGN_TRAP_EN, there SHALL be no misalign port and no HALT state.
- Redirect targets SHALL be forced word-aligned by clearing bits [1:0].

Verification
REQ-036 Reset, memory returning 32'h2408_0005 with ready one cycle after req, stall=0 -> imem_addr 0, then 4, then 8; instr_valid pulses once per instruction; opcode=6'b001001; fetch_count 1,2,3.
REQ-037 ready delayed 3 cycles in WAIT -> imem_addr stable and imem_req high throughout; instr latched only on the ready cycle.
REQ-038 In VALID with stall=1 for 4 cycles, branch_taken=1 asserted mid-stall then dropped -> instr/pc held; no redirect; next fetch at pc+4.
REQ-039 In VALID at pc=32'h0000_1000 with jump=1, jump_index=26'h000_0040 and branch_taken=1, branch_target=32'h0000_2000 -> next imem_addr=32'h0000_0100 (jump wins).
REQ-040 rst pulsed during WAIT, stale ready the next cycle -> ready ignored; fetch restarts at RESET_PC; fetch_count=0.
REQ-041 Misaligned redirect to 32'h0000_2002 -> with the macro defined: misalign=1, HALT, no further requests until rst; without the macro: next imem_addr=32'h0000_2000.
